twiddle_gen: RTL and testbench

- Read-side master for SIN_LUT. Walks a phase sequence, issues LUT addresses and captures registered LUT data.
- Emits complex twiddle pairs (cos, −sin) to the FFT butterfly datapath over a valid/ready handshake.
- Time-multiplexes one LUT port: cos is read at phase+QUARTER, sin at phase.
- Sits between the FFT control sequencer (start/step/count) and the butterfly.

---
 rtl/sa_pkg.sv | 17 +
 rtl/sat_negate.sv | 16 +
 rtl/twiddle_gen.sv | 128 ++++++++++++
 tb/tb_twiddle_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Constants shared by the sine LUT, the twiddle generator and the FFT control.
package sa_pkg;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 18;
    localparam int unsigned QUARTER = 2 ** (ADDR_W - 2);
    localparam int unsigned CNT_W   = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_C = 3'd1,
        CAP_C  = 3'd2,
        CAP_S  = 3'd3,
        OUT    = 3'd4
    } tw_state_t;

endpackage

// File: rtl/sat_negate.sv
// Two's-complement negation that saturates the most negative code to the most positive one.
module sat_negate #(
    parameter int unsigned W = 18
) (
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y_c
);

    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};

    always_comb begin
        y_c = (x == MIN_VAL) ? MAX_VAL : -x;
    end

endmodule

// File: rtl/twiddle_gen.sv
// Walks a phase sequence over one shared SIN_LUT port and emits (cos, +/-sin) twiddle pairs
// to the butterfly over a valid/ready handshake.
module twiddle_gen
    import sa_pkg::*;
#(
    parameter bit NEG_SIN = 1'b1
) (
    input  logic                     Clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        step,
    input  logic [CNT_W-1:0]         count,
    output logic [ADDR_W-1:0]        lut_addr,
    input  logic signed [DATA_W-1:0] lut_dout,
    output logic signed [DATA_W-1:0] tw_cos,
    output logic signed [DATA_W-1:0] tw_sin,
    output logic                     tw_valid,
    input  logic                     tw_ready,
    output logic                     busy,
    output logic                     done
);

    tw_state_t                state, state_n;
    logic [ADDR_W-1:0]        step_r, step_n;
    logic [ADDR_W-1:0]        phase, phase_n, phase_step;
    logic [CNT_W-1:0]         rem, rem_n;
    logic signed [DATA_W-1:0] cos_r, cos_n;
    logic [ADDR_W-1:0]        lut_addr_n;
    logic signed [DATA_W-1:0] tw_cos_n, tw_sin_n, neg_c;
    logic                     tw_valid_n, busy_n, done_n;

    sat_negate #(.W(DATA_W)) u_sat_negate (
        .x   (lut_dout),
        .y_c (neg_c)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            state    <= IDLE;
            step_r   <= '0;
            phase    <= '0;
            rem      <= '0;
            cos_r    <= '0;
            lut_addr <= '0;
            tw_cos   <= '0;
            tw_sin   <= '0;
            tw_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            step_r   <= step_n;
            phase    <= phase_n;
            rem      <= rem_n;
            cos_r    <= cos_n;
            lut_addr <= lut_addr_n;
            tw_cos   <= tw_cos_n;
            tw_sin   <= tw_sin_n;
            tw_valid <= tw_valid_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // The cos address (phase+QUARTER) is presented first, then the sin address (phase).
    always_comb begin
        state_n    = state;
        step_n     = step_r;
        phase_n    = phase;
        rem_n      = rem;
        cos_n      = cos_r;
        lut_addr_n = lut_addr;
        tw_cos_n   = tw_cos;
        tw_sin_n   = tw_sin;
        tw_valid_n = tw_valid;
        busy_n     = busy;
        done_n     = 1'b0;
        phase_step = phase + step_r;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        step_n     = step;
                        rem_n      = count;
                        phase_n    = '0;
                        lut_addr_n = ADDR_W'(QUARTER);
                        busy_n     = 1'b1;
                        state_n    = WAIT_C;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            WAIT_C: begin
                lut_addr_n = phase;
                state_n    = CAP_C;
            end
            CAP_C: begin
                cos_n   = lut_dout;
                state_n = CAP_S;
            end
            CAP_S: begin
                tw_cos_n   = cos_r;
                tw_sin_n   = NEG_SIN ? neg_c : lut_dout;
                tw_valid_n = 1'b1;
                state_n    = OUT;
            end
            OUT: begin
                if (tw_ready) begin
                    tw_valid_n = 1'b0;
                    if (rem == CNT_W'(1)) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        rem_n      = rem - CNT_W'(1);
                        phase_n    = phase_step;
                        lut_addr_n = phase_step + ADDR_W'(QUARTER);
                        state_n    = WAIT_C;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen: two instances (NEG_SIN=1 and 0) share stimulus and a sine LUT model.
module tb_twiddle_gen;
    import sa_pkg::*;

    localparam int LUT_N = 2 ** ADDR_W;
    localparam int QTR   = int'(QUARTER);
    localparam int PEAK  = 131071;

    typedef struct {
        int c;
        int sn;
        int sp;
    } pair_t;

    logic Clk = 1'b0;
    logic reset, start, tw_ready;
    logic [ADDR_W-1:0] step;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic signed [DATA_W-1:0] dout_a, dout_b, cos_a, sin_a, cos_b, sin_b;
    logic valid_a, valid_b, busy_a, busy_b, done_a, done_b;

    int    lut [LUT_N];
    pair_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    pair_cnt = 0;
    int    last_acc = 0;
    bit    gap_check = 1'b0;
    bit    stalled = 1'b0;
    int    hold_cos, hold_sin, hold_addr;

    always #5 Clk = ~Clk;

    twiddle_gen #(.NEG_SIN(1'b1)) dut_a (
        .Clk(Clk), .reset(reset), .start(start), .step(step), .count(count),
        .lut_addr(addr_a), .lut_dout(dout_a), .tw_cos(cos_a), .tw_sin(sin_a),
        .tw_valid(valid_a), .tw_ready(tw_ready), .busy(busy_a), .done(done_a)
    );

    twiddle_gen #(.NEG_SIN(1'b0)) dut_b (
        .Clk(Clk), .reset(reset), .start(start), .step(step), .count(count),
        .lut_addr(addr_b), .lut_dout(dout_b), .tw_cos(cos_b), .tw_sin(sin_b),
        .tw_valid(valid_b), .tw_ready(tw_ready), .busy(busy_b), .done(done_b)
    );

    // Registered-read sine LUT model, one copy per instance.
    always @(posedge Clk) begin
        dout_a <= DATA_W'(lut[addr_a]);
        dout_b <= DATA_W'(lut[addr_b]);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int satneg(input int x);
        return (x == -(PEAK + 1)) ? PEAK : -x;
    endfunction

    // Reference: pair k uses phase k*step mod 2^ADDR_W; cos from phase+QUARTER, sin from phase.
    task automatic push_expected(input int s, input int c);
        for (int k = 0; k < c; k++) begin
            int    p;
            pair_t e;
            p    = (k * s) % LUT_N;
            e.c  = lut[(p + QTR) % LUT_N];
            e.sp = lut[p];
            e.sn = satneg(lut[p]);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted pair and checks protocol rules.
    always @(negedge Clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (stalled) begin
                chk("stall_valid", int'(valid_a), 1);
                chk("stall_cos", int'(cos_a), hold_cos);
                chk("stall_sin", int'(sin_a), hold_sin);
                chk("stall_addr", int'(addr_a), hold_addr);
            end
            if (done_a) begin
                done_cnt++;
                chk("done_vs_valid", int'(valid_a), 0);
                chk("done_vs_busy", int'(busy_a), 0);
            end
            if (valid_a && tw_ready) begin
                chk("queue_nonempty", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    pair_t e;
                    e = exp_q.pop_front();
                    chk("cos_neg", int'(cos_a), e.c);
                    chk("sin_neg", int'(sin_a), e.sn);
                    chk("valid_pos", int'(valid_b), 1);
                    chk("cos_pos", int'(cos_b), e.c);
                    chk("sin_pos", int'(sin_b), e.sp);
                end
                if (gap_check && pair_cnt > 0)
                    chk("pair_gap", cyc - last_acc, 4);
                last_acc = cyc;
                pair_cnt++;
            end
            stalled   = valid_a && !tw_ready;
            hold_cos  = int'(cos_a);
            hold_sin  = int'(sin_a);
            hold_addr = int'(addr_a);
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_addr"}, int'(addr_a), 0);
        chk({tag, "_cos"}, int'(cos_a), 0);
        chk({tag, "_sin"}, int'(sin_a), 0);
        chk({tag, "_valid"}, int'(valid_a), 0);
        chk({tag, "_busy"}, int'(busy_a), 0);
        chk({tag, "_done"}, int'(done_a), 0);
        chk({tag, "_valid_b"}, int'(valid_b), 0);
        chk({tag, "_sin_b"}, int'(sin_b), 0);
    endtask

    // mode 0: ready held high; 1: random ready; 2: 5-cycle stall on pair 2. poke: start pulses while busy.
    task automatic run_seq(input int s, input int c, input int mode, input bit poke);
        int budget;
        int stall_left;
        @(posedge Clk); #1;
        step      = ADDR_W'(s);
        count     = CNT_W'(c);
        start     = 1'b1;
        tw_ready  = 1'b1;
        push_expected(s, c);
        done_cnt  = 0;
        pair_cnt  = 0;
        gap_check = (mode == 0);
        @(posedge Clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy_a), int'(c != 0));
        if (c != 0) begin
            @(posedge Clk); #1;
            @(posedge Clk); #1;
            chk("valid_before_latency", int'(valid_a), 0);
            @(posedge Clk); #1;
            chk("valid_at_latency", int'(valid_a), 1);
        end
        stall_left = 5;
        budget     = 40 * c + 20;
        while (done_cnt == 0 && budget > 0) begin
            @(posedge Clk); #1;
            budget--;
            case (mode)
                0: tw_ready = 1'b1;
                1: tw_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (pair_cnt == 1 && valid_a && stall_left > 0) begin
                        tw_ready = 1'b0;
                        stall_left--;
                    end else begin
                        tw_ready = 1'b1;
                    end
                end
            endcase
            if (poke && pair_cnt == 1 && busy_a) begin
                start = 1'b1;
                count = CNT_W'(7);
                step  = ADDR_W'(s + 1);
            end else begin
                start = 1'b0;
            end
        end
        start    = 1'b0;
        tw_ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("pair_count", pair_cnt, c);
        chk("queue_drained", exp_q.size(), 0);
        chk("busy_after_done", int'(busy_a), 0);
        chk("done_low_after", int'(done_a), 0);
        exp_q.delete();
    endtask

    task automatic reset_mid_sequence();
        @(posedge Clk); #1;
        step     = ADDR_W'(3);
        count    = CNT_W'(5);
        start    = 1'b1;
        tw_ready = 1'b1;
        done_cnt = 0;
        pair_cnt = 0;
        @(posedge Clk); #1;
        start = 1'b0;
        @(posedge Clk); #1;
        reset = 1'b1;
        @(posedge Clk); #1;
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        exp_q.delete();
        repeat (4) @(posedge Clk);
        #1;
        chk("no_done_after_reset", done_cnt, 0);
        chk("no_pair_after_reset", pair_cnt, 0);
    endtask

    initial begin
        for (int i = 0; i < LUT_N; i++) begin
            real v;
            v = 131071.0 * $sin(2.0 * 3.14159265358979 * real'(i) / real'(LUT_N));
            lut[i] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        end
        reset    = 1'b1;
        start    = 1'b0;
        tw_ready = 1'b0;
        step     = '0;
        count    = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;

        run_seq(1, 4, 0, 1'b0);
        run_seq(256, 4, 0, 1'b0);
        run_seq(5, 6, 2, 1'b0);
        lut[0] = -(PEAK + 1);
        run_seq(256, 4, 0, 1'b0);
        lut[0] = 0;
        run_seq(9, 0, 0, 1'b0);
        run_seq(17, 5, 1, 1'b1);
        reset_mid_sequence();
        run_seq(1, 3, 0, 1'b0);
        run_seq(1000, 5, 0, 1'b0);
        for (int n = 0; n < 6; n++)
            run_seq(int'($urandom_range(0, LUT_N - 1)), int'($urandom_range(1, 6)), 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
